// File: rtl/apb_node_pkg.sv
// Shared types and constants for the registered APB demux node (apb_node_pipe).
package apb_node_pkg;

   typedef enum logic [2:0] {
      NODE_IDLE   = 3'd0,
      NODE_SETUP  = 3'd1,
      NODE_ACCESS = 3'd2,
      NODE_RESP   = 3'd3,
      NODE_ERR    = 3'd4
   } node_state_e;

   // Read data returned on unmapped-address and watchdog error responses.
   localparam logic [31:0] NODE_ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/apb_node_decode.sv
// Address decoder: inclusive per-port range compare; lowest-index port wins on overlap.
module apb_node_decode #(
   parameter int NB_MASTER      = 8,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int IDX_W          = 3
) (
   input  logic [APB_ADDR_WIDTH-1:0]           addr,
   input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr,
   input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr,
   output logic                                hit,
   output logic [IDX_W-1:0]                    idx
);

   // Scan from the top index downwards so the lowest matching port is the last write.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = NB_MASTER - 1; i >= 0; i--) begin
         if ((addr >= start_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
             (addr <= end_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/apb_node_pipe.sv
// Registered 1-to-NB_MASTER APB demux node with unmapped-address error response.
// Optional ACCESS watchdog enabled by defining APB_NODE_TIMEOUT_EN.
module apb_node_pipe
   import apb_node_pkg::*;
#(
   parameter int NB_MASTER      = 8,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                psel_i,
   input  logic                                penable_i,
   input  logic                                pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0]           paddr_i,
   input  logic [APB_DATA_WIDTH-1:0]           pwdata_i,
   output logic [APB_DATA_WIDTH-1:0]           prdata_o,
   output logic                                pready_o,
   output logic                                pslverr_o,
   output logic [NB_MASTER-1:0]                psel_o,
   output logic [NB_MASTER-1:0]                penable_o,
   output logic [NB_MASTER-1:0]                pwrite_o,
   output logic [NB_MASTER*APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [NB_MASTER*APB_DATA_WIDTH-1:0] pwdata_o,
   input  logic [NB_MASTER*APB_DATA_WIDTH-1:0] prdata_i,
   input  logic [NB_MASTER-1:0]                pready_i,
   input  logic [NB_MASTER-1:0]                pslverr_i,
   input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
   input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i
);

   localparam int IDX_W = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   node_state_e               state;
   logic                      dec_hit;
   logic [IDX_W-1:0]          dec_idx;
   logic [IDX_W-1:0]          idx_p0;
   logic [APB_ADDR_WIDTH-1:0] addr_p0;
   logic [APB_DATA_WIDTH-1:0] wdata_p0;
   logic                      write_p0;
   logic                      drop_p0;
   logic [APB_DATA_WIDTH-1:0] rdata_p1;
   logic                      slverr_p1;
   logic [NB_MASTER-1:0]      sel_1h;
   logic                      tgt_ready;
   logic                      tgt_err;
   logic [APB_DATA_WIDTH-1:0] tgt_rdata;
   logic                      timeout;
   logic                      accept;

   apb_node_decode #(
      .NB_MASTER      (NB_MASTER),
      .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
      .IDX_W          (IDX_W)
   ) u_decode (
      .addr       (paddr_i),
      .start_addr (start_addr_i),
      .end_addr   (end_addr_i),
      .hit        (dec_hit),
      .idx        (dec_idx)
   );

   // Selected-port one-hot and response mux driven by the captured index.
   always_comb begin
      sel_1h    = '0;
      tgt_ready = 1'b0;
      tgt_err   = 1'b0;
      tgt_rdata = '0;
      for (int i = 0; i < NB_MASTER; i++) begin
         if (idx_p0 == IDX_W'(i)) begin
            sel_1h[i] = 1'b1;
            tgt_ready = pready_i[i];
            tgt_err   = pslverr_i[i];
            tgt_rdata = prdata_i[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
         end
      end
   end

`ifdef APB_NODE_TIMEOUT_EN
   logic [CNT_W-1:0] wd_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wd_cnt <= '0;
      end else if (state == NODE_SETUP) begin
         wd_cnt <= '0;
      end else if (state == NODE_ACCESS) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign timeout = (state == NODE_ACCESS) && !tgt_ready &&
                    (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic [CNT_W-1:0] unused_timeout_lim;

   assign unused_timeout_lim = CNT_W'(TIMEOUT_CYCLES - 1);
   assign timeout            = 1'b0;
`endif

   assign accept = (state == NODE_IDLE) && psel_i && !penable_i;

   // Stage p0: request capture and FSM
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= NODE_IDLE;
         idx_p0   <= '0;
         addr_p0  <= '0;
         wdata_p0 <= '0;
         write_p0 <= 1'b0;
         drop_p0  <= 1'b0;
      end else begin
         case (state)
            NODE_IDLE: begin
               if (accept) begin
                  idx_p0   <= dec_idx;
                  addr_p0  <= paddr_i;
                  wdata_p0 <= pwdata_i;
                  write_p0 <= pwrite_i;
                  drop_p0  <= 1'b0;
                  state    <= dec_hit ? NODE_SETUP : NODE_ERR;
               end
            end
            NODE_SETUP: begin
               if (!psel_i) drop_p0 <= 1'b1;
               state <= NODE_ACCESS;
            end
            NODE_ACCESS: begin
               if (!psel_i) drop_p0 <= 1'b1;
               if (tgt_ready || timeout) state <= NODE_RESP;
            end
            NODE_RESP: state <= NODE_IDLE;
            NODE_ERR:  state <= NODE_IDLE;
            default:   state <= NODE_IDLE;
         endcase
      end
   end

   // Stage p1: downstream response capture; only observed through the RESP gate below
   always_ff @(posedge clk_i) begin
      if (state == NODE_ACCESS) begin
         if (tgt_ready) begin
            rdata_p1  <= tgt_rdata;
            slverr_p1 <= tgt_err;
         end else if (timeout) begin
            rdata_p1  <= APB_DATA_WIDTH'(NODE_ERR_RDATA);
            slverr_p1 <= 1'b1;
         end
      end
   end

   assign psel_o    = ((state == NODE_SETUP) || (state == NODE_ACCESS)) ? sel_1h : '0;
   assign penable_o = (state == NODE_ACCESS) ? sel_1h : '0;
   assign pwrite_o  = {NB_MASTER{write_p0}};
   assign paddr_o   = {NB_MASTER{addr_p0}};
   assign pwdata_o  = {NB_MASTER{wdata_p0}};

   assign pready_o  = (state == NODE_ERR) || ((state == NODE_RESP) && !drop_p0);
   assign pslverr_o = (state == NODE_ERR) || ((state == NODE_RESP) && !drop_p0 && slverr_p1);
   assign prdata_o  = ((state == NODE_RESP) && !drop_p0) ? rdata_p1
                                                         : APB_DATA_WIDTH'(NODE_ERR_RDATA);

endmodule

// File: tb/tb_apb_node_pipe.sv
// Directed bench for apb_node_pipe: four ports, behavioural wait-state targets.
module tb_apb_node_pipe;

   localparam int NB = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            psel_i, penable_i, pwrite_i;
   logic [AW-1:0]   paddr_i;
   logic [DW-1:0]   pwdata_i;
   logic [DW-1:0]   prdata_o;
   logic            pready_o, pslverr_o;
   logic [NB-1:0]   psel_o, penable_o, pwrite_o;
   logic [NB*AW-1:0] paddr_o;
   logic [NB*DW-1:0] pwdata_o;
   logic [NB*DW-1:0] prdata_i;
   logic [NB-1:0]   pready_i, pslverr_i;
   logic [NB*AW-1:0] start_addr_i, end_addr_i;

   int              wait_cfg [NB];
   int              wcnt [NB];
   logic [NB-1:0]   force_rdy;

   int              n_chk = 0;
   int              n_err = 0;

   // per-transfer observations
   int              lat, rcnt, en_cyc;
   logic [DW-1:0]   rd;
   logic            err;
   logic [NB-1:0]   sel_or, sel_t1, en_t1, en_t2, wr_t1;
   logic [DW-1:0]   wd_t1;

   always #5 clk_i = ~clk_i;

   apb_node_pipe #(
      .NB_MASTER      (NB),
      .APB_ADDR_WIDTH (AW),
      .APB_DATA_WIDTH (DW),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .psel_i       (psel_i),
      .penable_i    (penable_i),
      .pwrite_i     (pwrite_i),
      .paddr_i      (paddr_i),
      .pwdata_i     (pwdata_i),
      .prdata_o     (prdata_o),
      .pready_o     (pready_o),
      .pslverr_o    (pslverr_o),
      .psel_o       (psel_o),
      .penable_o    (penable_o),
      .pwrite_o     (pwrite_o),
      .paddr_o      (paddr_o),
      .pwdata_o     (pwdata_o),
      .prdata_i     (prdata_i),
      .pready_i     (pready_i),
      .pslverr_i    (pslverr_i),
      .start_addr_i (start_addr_i),
      .end_addr_i   (end_addr_i)
   );

   // Target model: port i answers after wait_cfg[i] low ACCESS cycles.
   always @(posedge clk_i) begin
      for (int i = 0; i < NB; i++) begin
         if (penable_o[i] && !pready_i[i]) wcnt[i] <= wcnt[i] + 1;
         else                              wcnt[i] <= 0;
      end
   end

   always_comb begin
      pready_i = '0;
      for (int i = 0; i < NB; i++)
         pready_i[i] = (penable_o[i] && (wcnt[i] >= wait_cfg[i])) || force_rdy[i];
   end

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // One upstream transfer; observes 16 cycles after the setup cycle T.
   // drop_at > 0 releases psel_i from that cycle on (protocol violation).
   task automatic xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                       input int drop_at);
      lat = 0; rcnt = 0; en_cyc = 0; rd = '0; err = 1'b0;
      sel_or = '0; sel_t1 = '0; en_t1 = '0; en_t2 = '0; wr_t1 = '0; wd_t1 = '0;
      @(posedge clk_i); #1;
      psel_i = 1'b1; penable_i = 1'b0; paddr_i = a; pwrite_i = w; pwdata_i = wd;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk_i); #1;
         if (lat != 0 || (drop_at > 0 && c >= drop_at)) begin
            psel_i = 1'b0; penable_i = 1'b0;
         end else begin
            penable_i = 1'b1;
         end
         @(negedge clk_i);
         sel_or |= psel_o;
         if (penable_o != '0) en_cyc++;
         if (c == 1) begin
            sel_t1 = psel_o; en_t1 = penable_o; wr_t1 = pwrite_o;
            wd_t1  = pwdata_o[1*DW +: DW];
         end
         if (c == 2) en_t2 = penable_o;
         if (pready_o) begin
            rcnt++;
            if (lat == 0) begin
               lat = c; rd = prdata_o; err = pslverr_o;
            end
         end
      end
      psel_i = 1'b0; penable_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = '0; pwdata_i = '0;
      force_rdy = '0;
      pslverr_i = 4'b1000;
      for (int i = 0; i < NB; i++) begin
         wait_cfg[i] = 0;
         wcnt[i] = 0;
      end
      start_addr_i = {32'hF000_0000, 32'h0000_2000, 32'h0000_2000, 32'h0000_1000};
      end_addr_i   = {32'hF000_00FF, 32'h0000_20FF, 32'h0000_2FFF, 32'h0000_1FFF};
      prdata_i     = {32'hDDDD_0003, 32'hCCCC_0002, 32'hAAAA_0001, 32'h1234_5678};

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_val("rst_pready", pready_o, 0);
      check_val("rst_pslverr", pslverr_o, 0);
      check_val("rst_psel", psel_o, 0);
      check_val("rst_penable", penable_o, 0);
      check_val("rst_prdata", prdata_o, 0);
      check_val("rst_paddr", paddr_o, 0);
      rst_i = 1'b0;

      // write to port1, zero wait
      xfer(32'h0000_2004, 1'b1, 32'hCAFE_0001, 0);
      check_val("wr_psel_t1", sel_t1, 4'b0010);
      check_val("wr_pen_t1", en_t1, 4'b0000);
      check_val("wr_pen_t2", en_t2, 4'b0010);
      check_val("wr_pwdata", wd_t1, 32'hCAFE_0001);
      check_val("wr_pwrite", wr_t1, 4'b1111);
      check_val("wr_latency", lat, 3);
      check_val("wr_pslverr", err, 0);
      check_val("wr_ready_cnt", rcnt, 1);

      // read port0 with 3 wait states
      wait_cfg[0] = 3;
      xfer(32'h0000_1010, 1'b0, 32'h0, 0);
      check_val("rd_wait_latency", lat, 6);
      check_val("rd_wait_data", rd, 32'h1234_5678);
      check_val("rd_wait_ready_cnt", rcnt, 1);
      check_val("rd_wait_access_cyc", en_cyc, 4);
      wait_cfg[0] = 0;

      // unmapped
      xfer(32'h0000_9000, 1'b0, 32'h0, 0);
      check_val("unmap_latency", lat, 1);
      check_val("unmap_pslverr", err, 1);
      check_val("unmap_prdata", rd, 0);
      check_val("unmap_psel", sel_or, 0);

      // range boundaries: end inclusive, just below start unmapped
      xfer(32'h0000_1FFF, 1'b0, 32'h0, 0);
      check_val("edge_hi_psel", sel_or, 4'b0001);
      check_val("edge_hi_latency", lat, 3);
      xfer(32'h0000_0FFF, 1'b0, 32'h0, 0);
      check_val("edge_lo_pslverr", err, 1);
      check_val("edge_lo_latency", lat, 1);

      // overlap: port1 and port2 both cover 0x2010
      xfer(32'h0000_2010, 1'b0, 32'h0, 0);
      check_val("ovl_psel", sel_or, 4'b0010);
      check_val("ovl_data", rd, 32'hAAAA_0001);

      // downstream error propagated from port3
      xfer(32'hF000_0040, 1'b0, 32'h0, 0);
      check_val("slverr_flag", err, 1);
      check_val("slverr_data", rd, 32'hDDDD_0003);

      // psel dropped during ACCESS: downstream completes, no upstream ready
      wait_cfg[1] = 3;
      xfer(32'h0000_2008, 1'b0, 32'h0, 2);
      check_val("drop_ready_cnt", rcnt, 0);
      check_val("drop_access_cyc", en_cyc, 4);
      wait_cfg[1] = 0;
      xfer(32'h0000_2008, 1'b0, 32'h0, 0);
      check_val("drop_next_latency", lat, 3);

      // reset asserted while in ACCESS
      wait_cfg[0] = 1000;
      @(posedge clk_i); #1;
      psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h0000_1010; pwrite_i = 1'b0;
      @(posedge clk_i); #1 penable_i = 1'b1;
      @(posedge clk_i);
      @(posedge clk_i);
      @(negedge clk_i);
      check_val("mid_access_pen", penable_o, 4'b0001);
      rst_i = 1'b1;
      #1;
      check_val("mid_rst_psel", psel_o, 0);
      check_val("mid_rst_penable", penable_o, 0);
      check_val("mid_rst_pready", pready_o, 0);
      check_val("mid_rst_paddr", paddr_o, 0);
      psel_i = 1'b0; penable_i = 1'b0;
      wait_cfg[0] = 0;
      @(posedge clk_i); #1 rst_i = 1'b0;
      xfer(32'h0000_1020, 1'b1, 32'h5555_AAAA, 0);
      check_val("post_rst_latency", lat, 3);
      check_val("post_rst_psel", sel_or, 4'b0001);

`ifdef APB_NODE_TIMEOUT_EN
      // target never ready: four ACCESS cycles then error response
      wait_cfg[0] = 1000;
      xfer(32'h0000_1030, 1'b0, 32'h0, 0);
      check_val("to_latency", lat, 6);
      check_val("to_access_cyc", en_cyc, 4);
      check_val("to_pslverr", err, 1);
      check_val("to_prdata", rd, 0);
      check_val("to_ready_cnt", rcnt, 1);
      rcnt = 0;
      force_rdy[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         if (pready_o) rcnt++;
      end
      force_rdy[0] = 1'b0;
      check_val("to_late_ready", rcnt, 0);
      wait_cfg[0] = 0;
`endif

      repeat (2) @(posedge clk_i);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
